// File: rtl/trace_8085_pkg.sv
// -----------------------------------------------------------------------------
// trace_8085_pkg
// Shared definitions for the 8085 execution-trace capture unit:
//   - capture state encoding
//   - record-width helper (accounts for the optional timestamp field)
//   - field offsets inside a record, counted from the LSB of the
//     architectural part (which sits just above the timestamp, if present)
// Optional feature macro: TRACE_TIMESTAMP_EN (appends a cycle timestamp).
// -----------------------------------------------------------------------------
package trace_8085_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_POST    = 2'd2,
        ST_STOPPED = 2'd3
    } trace_state_e;

`ifdef TRACE_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    // Offsets of the architectural fields relative to the record base.
    localparam int Z_OFS   = 0;
    localparam int CY_OFS  = 1;
    localparam int ACC_OFS = 2;

    // Record layout, MSB to LSB: {pc, acc, cy, z [, timestamp]}
    function automatic int rec_w(input int pc_w, input int data_w, input int ts_w);
        return pc_w + data_w + 2 + (TS_EN ? ts_w : 0);
    endfunction

    // Bit position where the architectural fields start.
    function automatic int rec_base(input int ts_w);
        return TS_EN ? ts_w : 0;
    endfunction

endpackage

// File: rtl/trace_ram_8085.sv
// -----------------------------------------------------------------------------
// trace_ram_8085
// DEPTH x REC_W record store. Synchronous write, registered read with a read
// enable so the output holds its value between reads. The array itself has no
// reset; only the read register is cleared by rst_n.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (read register only)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable
//   raddr  in   read address
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module trace_ram_8085
    import trace_8085_pkg::*;
#(
    parameter int REC_W = 18,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [REC_W-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [REC_W-1:0]         rdata
);

    logic [REC_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/trace_capture_8085.sv
// -----------------------------------------------------------------------------
// trace_capture_8085
// Samples the 8085 architectural snapshot {pc, acc, cy, z} every SAMPLE_DIV
// clocks into a DEPTH-entry circular buffer. Mode 0 stops when the buffer is
// full; mode 1 wraps continuously and stops POST_TRIG samples after trig.
// Once stopped, records are read back oldest-first, one per rd_req, with a
// one-cycle latency.
// Optional feature macro: TRACE_TIMESTAMP_EN -- appends a free-running
// TS_W-bit cycle counter (value on the sample cycle) as the record LSBs.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   pc         in   program counter            [PC_W]
//   acc        in   accumulator                [DATA_W]
//   cy, z      in   carry / zero flags
//   arm        in   pulse: clear buffer and start capture (IDLE/STOPPED only)
//   wrap_mode  in   0 = stop when full, 1 = wrap with trigger (latched on arm)
//   trig       in   trigger pulse (wrap mode, CAPTURE state only)
//   rd_req     in   readout request, one record per pulse (STOPPED only)
//   rd_valid   out  rd_data valid this cycle
//   rd_data    out  record, pc in the MSBs
//   count      out  records currently held
//   capturing  out  high in CAPTURE or POST
//   done       out  high in STOPPED
// -----------------------------------------------------------------------------
module trace_capture_8085
    import trace_8085_pkg::*;
#(
    parameter int PC_W       = 8,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 16,
    parameter int SAMPLE_DIV = 4,
    parameter int POST_TRIG  = 4,
    parameter int TS_W       = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [PC_W-1:0]                        pc,
    input  logic [DATA_W-1:0]                      acc,
    input  logic                                   cy,
    input  logic                                   z,
    input  logic                                   arm,
    input  logic                                   wrap_mode,
    input  logic                                   trig,
    input  logic                                   rd_req,
    output logic                                   rd_valid,
    output logic [rec_w(PC_W, DATA_W, TS_W)-1:0]   rd_data,
    output logic [$clog2(DEPTH+1)-1:0]             count,
    output logic                                   capturing,
    output logic                                   done
);

    localparam int REC_W = rec_w(PC_W, DATA_W, TS_W);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL_M1 = CNT_W'(DEPTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [PTR_W-1:0] POST_LAST   = PTR_W'(POST_TRIG - 1);

    trace_state_e     state_q, state_d;
    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] rp_q, rp_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [PTR_W-1:0] post_cnt_q, post_cnt_d;
    logic             mode_q, mode_d;
    logic             rd_valid_q, rd_valid_d;

    logic             active;
    logic             sample;
    logic             rd_fire;
    logic [REC_W-1:0] wr_rec;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    assign wr_rec = {pc, acc, cy, z, ts_q};
`else
    assign wr_rec = {pc, acc, cy, z};
`endif

    always_comb begin
        state_d    = state_q;
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        div_d      = div_q;
        post_cnt_d = post_cnt_q;
        mode_d     = mode_q;
        rd_valid_d = 1'b0;
        rd_fire    = 1'b0;

        active = (state_q == ST_CAPTURE) || (state_q == ST_POST);
        sample = active && (div_q == DIV_LAST);

        if (active) begin
            div_d = sample ? '0 : div_q + 1'b1;
        end

        // Once full (only reachable in wrap mode) the oldest record is
        // overwritten, so the read pointer follows the write pointer.
        if (sample) begin
            wp_d = wp_q + 1'b1;
            if (count_q == CNT_FULL) begin
                rp_d = rp_q + 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d    = ST_CAPTURE;
                    wp_d       = '0;
                    rp_d       = '0;
                    count_d    = '0;
                    div_d      = '0;
                    post_cnt_d = '0;
                    mode_d     = wrap_mode;
                end
            end
            ST_CAPTURE: begin
                if (!mode_q) begin
                    if (sample && (count_q == CNT_FULL_M1)) begin
                        state_d = ST_STOPPED;
                    end
                end else if (trig) begin
                    // A sample taken in the trigger cycle is not part of
                    // the post-trigger window.
                    post_cnt_d = '0;
                    state_d    = (POST_TRIG == 0) ? ST_STOPPED : ST_POST;
                end
            end
            ST_POST: begin
                if (sample) begin
                    post_cnt_d = post_cnt_q + 1'b1;
                    if (post_cnt_q == POST_LAST) begin
                        state_d = ST_STOPPED;
                    end
                end
            end
            ST_STOPPED: begin
                if (arm) begin
                    state_d    = ST_CAPTURE;
                    wp_d       = '0;
                    rp_d       = '0;
                    count_d    = '0;
                    div_d      = '0;
                    post_cnt_d = '0;
                    mode_d     = wrap_mode;
                end else if (rd_req && (count_q != '0)) begin
                    rd_fire    = 1'b1;
                    rd_valid_d = 1'b1;
                    rp_d       = rp_q + 1'b1;
                    count_d    = count_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            div_q      <= '0;
            post_cnt_q <= '0;
            mode_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            div_q      <= div_d;
            post_cnt_q <= post_cnt_d;
            mode_q     <= mode_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    trace_ram_8085 #(
        .REC_W (REC_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (reset),
        .we    (sample),
        .waddr (wp_q),
        .wdata (wr_rec),
        .re    (rd_fire),
        .raddr (rp_q),
        .rdata (rd_data)
    );

    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign capturing = active;
    assign done      = (state_q == ST_STOPPED);

endmodule

// File: tb/tb_trace_capture_8085.sv
// -----------------------------------------------------------------------------
// tb_trace_capture_8085
// Scoreboard bench: the expected record for every sample cycle is queued as
// the snapshot is driven (oldest dropped when the wrap buffer overflows), and
// popped/compared whenever the DUT presents rd_valid.
// -----------------------------------------------------------------------------
module tb_trace_capture_8085;

    localparam int PC_W   = 8;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int SD     = 4;
    localparam int PT     = 2;
    localparam int TS_W   = 16;
`ifdef TRACE_TIMESTAMP_EN
    localparam int TSB = TS_W;
`else
    localparam int TSB = 0;
`endif
    localparam int BODY_W = PC_W + DATA_W + 2;
    localparam int REC_W  = BODY_W + TSB;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] acc;
    logic              cy, z, arm, wrap_mode, trig, rd_req;
    logic              rd_valid;
    logic [REC_W-1:0]  rd_data;
    logic [CNT_W-1:0]  count;
    logic              capturing, done;

    int n_chk = 0;
    int n_err = 0;
    logic [BODY_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    trace_capture_8085 #(
        .PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .SAMPLE_DIV(SD), .POST_TRIG(PT), .TS_W(TS_W)
    ) dut (
        .clk(clk), .reset(reset), .pc(pc), .acc(acc), .cy(cy), .z(z),
        .arm(arm), .wrap_mode(wrap_mode), .trig(trig), .rd_req(rd_req),
        .rd_valid(rd_valid), .rd_data(rd_data), .count(count),
        .capturing(capturing), .done(done)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Snapshot driven on cycle i after arm (pc=0 on the first cycle).
    function automatic logic [BODY_W-1:0] rec_of(input int i);
        logic [7:0] p, a;
        logic       c, zz;
        p  = 8'(i - 1);
        a  = 8'(i * 37 + 5);
        c  = ((i % 2) == 1);
        zz = ((i % 3) == 0);
        return {p, a, c, zz};
    endfunction

    task automatic drive(input int i);
        {pc, acc, cy, z} = rec_of(i);
    endtask

    task automatic run_capture(input bit mode, input int trig_at, input int budget);
        int  post_left;
        bit  stop;
        bit  smp;
        int  i;
        exp_q.delete();
        drive(0);
        arm = 1'b1;
        wrap_mode = mode;
        tick();
        arm = 1'b0;
        post_left = -1;
        stop = 1'b0;
        i = 1;
        while (!stop && i <= budget) begin
            drive(i);
            trig = (i == trig_at);
            smp = ((i % SD) == 0);
            if (smp) begin
                exp_q.push_back(rec_of(i));
                if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
            end
            if (!mode) begin
                if (smp && exp_q.size() == DEPTH) stop = 1'b1;
            end else if (post_left > 0) begin
                if (smp) begin
                    post_left--;
                    if (post_left == 0) stop = 1'b1;
                end
            end else if (post_left < 0 && trig) begin
                if (PT == 0) stop = 1'b1;
                else post_left = PT;
            end
            tick();
            if (!stop) check("capturing_run", 64'(capturing), 64'(1));
            i++;
        end
        trig = 1'b0;
        check("capture_stopped", 64'(stop), 64'(1));
        check("done", 64'(done), 64'(1));
        check("capturing_off", 64'(capturing), 64'(0));
        check("count_full", 64'(count), 64'(exp_q.size()));
    endtask

    task automatic read_out(input int nreq);
        logic [BODY_W-1:0] e;
        logic [REC_W-1:0]  last;
        bit                fire;
        bit                got_any;
        got_any = 1'b0;
        last = '0;
        e = '0;
        for (int k = 0; k <= nreq; k++) begin
            rd_req = (k < nreq);
            fire = rd_req && (exp_q.size() > 0);
            if (fire) e = exp_q.pop_front();
            tick();
            check("rd_valid", 64'(rd_valid), 64'(fire));
            if (fire && rd_valid) begin
                check("rd_rec", 64'(rd_data[REC_W-1 -: BODY_W]), 64'(e));
`ifdef TRACE_TIMESTAMP_EN
                if (got_any)
                    check("ts_step", 64'(16'(rd_data[TSB-1:0] - last[TSB-1:0])), 64'(SD));
`endif
                last = rd_data;
                got_any = 1'b1;
            end
        end
        rd_req = 1'b0;
        check("count_after_read", 64'(count), 64'(exp_q.size()));
        if (got_any) check("rd_hold", 64'(rd_data), 64'(last));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        arm = 1'b0; wrap_mode = 1'b0; trig = 1'b0; rd_req = 1'b0;
        drive(0);
        tick();
        tick();
        check("rst_rd_valid", 64'(rd_valid), 64'(0));
        check("rst_rd_data", 64'(rd_data), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_capturing", 64'(capturing), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        reset = 1'b1;
        tick();

        // Mode 0: stop when full; trig must be ignored.
        run_capture(1'b0, 10, 100);
        read_out(8);
        // Empty buffer: no further records.
        read_out(2);

        // Mode 1: 20 samples, trig, 2 post-trigger samples.
        run_capture(1'b1, 81, 300);
        read_out(8);

        // Mode 1: trig coincides with sample 10 (stored, not counted).
        run_capture(1'b1, 40, 300);
        read_out(3);

        // arm and rd_req together in STOPPED: arm wins.
        arm = 1'b1; rd_req = 1'b1; wrap_mode = 1'b0;
        tick();
        arm = 1'b0; rd_req = 1'b0;
        exp_q.delete();
        check("arm_rd_valid", 64'(rd_valid), 64'(0));
        check("arm_capturing", 64'(capturing), 64'(1));
        check("arm_count", 64'(count), 64'(0));
        for (int k = 0; k < 9; k++) tick();
        check("pre_rst_count", 64'(count), 64'(2));

        // Asynchronous reset in the middle of a capture.
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_count", 64'(count), 64'(0));
        check("midrst_capturing", 64'(capturing), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_rd_valid", 64'(rd_valid), 64'(0));
        reset = 1'b1;
        tick();
        check("post_rst_idle", 64'(capturing), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
